p3_exec_sequencer: RTL and testbench
====================================

# p3_exec_sequencer

Multi-cycle execute sequencer that sits directly downstream of the 8 x 16-bit register file and feeds its write port back. It accepts one operate command at a time and reads operand A, then operand B, through the register file's read port. It then applies a shift to B and an ALU operation, and writes the result back to a destination register. It also maintains Z/N/V status flags.

## Interface
Parameters:
- DATA_W, 16, datapath width; must equal the register file width.
- REG_AW, 3, register index width (8 registers).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept; high only in IDLE.
- cmd_rn_a  in  REG_AW  source register for operand A.
- cmd_rn_b  in  REG_AW  source register for operand B.
- cmd_rd  in  REG_AW  destination register.
- cmd_shift  in  2  B shift: 00 none, 01 shl1 (LSB←0), 10 lsr1 (MSB←0), 11 asr1 (MSB←MSB).
- cmd_aluop  in  2  00 A+B', 01 A−B', 10 A&B', 11 ~B'.
- rf_readnum  out  REG_AW  to register file readnum.
- rf_data_out  in  DATA_W  from register file data_out (combinational read).
- rf_writenum  out  REG_AW  to register file writenum.
- rf_write  out  1  to register file write.
- rf_data_in  out  DATA_W  to register file data_in.
- status  out  3  {V,N,Z}.
- done  out  1  one-cycle pulse on writeback.

## Operation
- States: IDLE → RD_A → RD_B → EXEC → WB → IDLE.
- IDLE: cmd_ready=1. If cmd_valid, latch all cmd_* fields and go to RD_A. Otherwise stay.
- RD_A: rf_readnum=rn_a; A latched from rf_data_out at the edge leaving RD_A.
- RD_B: rf_readnum=rn_b; B latched at the edge leaving RD_B.
- EXEC: B'=shift(B); C latched from the ALU; status latched.
- WB: rf_write=1, rf_writenum=rd, rf_data_in=C, done=1.
- Arithmetic: modulo 2^DATA_W; carry-out is discarded.
- Z = (C==0).
- N = C[DATA_W-1].
- V = signed overflow for add/sub; V=0 for AND/NOT.
- rd may equal rn_a or rn_b. Both reads complete before writeback, so the old values are used.
- cmd_* fields are ignored outside IDLE.

## Timing
- Accept edge T. RD_A, RD_B, EXEC and WB occupy cycles T+1 to T+4.
- The register file captures the result at the end of T+4. done is high in T+4.
- Throughput: one command per 5 cycles.
- A dependent command accepted in the IDLE cycle after WB reads the updated value.
- rf_write is high exactly one cycle per command and never outside WB.
- Reset values: state IDLE (cmd_ready=1), rf_readnum=0, rf_writenum=0, rf_write=0, rf_data_in=0, A=B=C=0, status=000, done=0.
- Reset asserted mid-command: immediate return to IDLE, rf_write drops asynchronously, no partial writeback, command lost, status cleared.

## Configuration
- P3_STATUS_FLAGS_EN defined: N and V computed as above.
- P3_STATUS_FLAGS_EN undefined: only Z computed; status[2:1] tied to 0 and the V logic is removed.

## Structure
- Shared package p3_pkg holds:
  - state enum (IDLE, RD_A, RD_B, EXEC, WB);
  - shift codes SH_NONE/SH_SHL/SH_LSR/SH_ASR;
  - ALU codes ALU_ADD/ALU_SUB/ALU_AND/ALU_NOT;
  - DATA_W/REG_AW defaults.
- One sub-module, p3_shift_alu: combinational shift + ALU + flag generation, instantiated in EXEC.

## Test plan
The bench instantiates this block with the 8 x 16 register file and preloads registers through the file's write port before releasing the sequencer.
- R0=0x0005, R1=0x0003; cmd rn_a=0, rn_b=1, rd=2, shift 00, op ADD → R2=0x0008, status=000, done at T+4, cmd_ready low T+1..T+4.
- cmd rn_a=1, rn_b=1, rd=3, op SUB → R3=0x0000, Z=1.
- R4=0x0000, R5=0x8001; rn_a=4, rn_b=5, shift 11, ADD → R6=0xC000, N=1. Shift 10 instead → 0x4000, N=0.
- R0=0x7FFF, R1=0x0001, ADD, rd=7 → R7=0x8000. status=110 with P3_STATUS_FLAGS_EN; 001→000 Z-only without it.
- rd=2 preset 0xBEEF; pull rst_n low during EXEC → rf_write never asserted, R2 stays 0xBEEF, cmd_ready=1, status=000.
- Back-to-back dependency: cmd1 writes R2=0x0008; cmd2 (rn_a=2, rn_b=2, ADD, rd=3) held valid → accepted the cycle after cmd1's WB, R3=0x0010.

Source files
------------

// File: rtl/p3_exec_sequencer_pkg.sv
// p3_pkg: sequencer state, shift/ALU encodings and default widths for the execute sequencer.
package p3_pkg;
  localparam int P3_DATA_W = 16;
  localparam int P3_REG_AW = 3;
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_t;
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_SHL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;
endpackage

// File: rtl/p3_exec_sequencer_shift_alu.sv
// p3_shift_alu: shifts B, applies the ALU op and forms {V,N,Z}; N and V exist only with P3_STATUS_FLAGS_EN.
module p3_shift_alu
  import p3_pkg::*;
#(
  parameter int DATA_W = P3_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        shift,
  input  logic [1:0]        aluop,
  output logic [DATA_W-1:0] c,
  output logic [2:0]        status
);
  logic [DATA_W-1:0] bs;
  always_comb begin
    bs = shift == SH_SHL ? {b[DATA_W-2:0], 1'b0} :
         shift == SH_LSR ? {1'b0, b[DATA_W-1:1]} :
         shift == SH_ASR ? {b[DATA_W-1], b[DATA_W-1:1]} : b;
    c = aluop == ALU_ADD ? a + bs :
        aluop == ALU_SUB ? a - bs :
        aluop == ALU_AND ? a & bs : ~bs;
  end
`ifdef P3_STATUS_FLAGS_EN
  logic v;
  always_comb
    v = aluop == ALU_ADD ? (a[DATA_W-1] == bs[DATA_W-1]) && (c[DATA_W-1] != a[DATA_W-1]) :
        aluop == ALU_SUB ? (a[DATA_W-1] != bs[DATA_W-1]) && (c[DATA_W-1] != a[DATA_W-1]) : 1'b0;
  assign status = {v, c[DATA_W-1], c == '0};
`else
  assign status = {2'b00, c == '0};
`endif
endmodule

// File: rtl/p3_exec_sequencer.sv
// p3_exec_sequencer: five-state read-A/read-B/execute/writeback sequencer around an external register file.
module p3_exec_sequencer
  import p3_pkg::*;
#(
  parameter int DATA_W = P3_DATA_W,
  parameter int REG_AW = P3_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [REG_AW-1:0] cmd_rn_a,
  input  logic [REG_AW-1:0] cmd_rn_b,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [1:0]        cmd_shift,
  input  logic [1:0]        cmd_aluop,
  output logic [REG_AW-1:0] rf_readnum,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic [REG_AW-1:0] rf_writenum,
  output logic              rf_write,
  output logic [DATA_W-1:0] rf_data_in,
  output logic [2:0]        status,
  output logic              done
);
  state_t state_q, state_d;
  logic [REG_AW-1:0] rn_b_q, rn_b_d, rd_q, rd_d, readnum_q, readnum_d;
  logic [1:0] shift_q, shift_d, op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, alu_c;
  logic [2:0] status_q, status_d, alu_status;
  logic wr_q, wr_d, ready_q, ready_d;
  p3_shift_alu #(.DATA_W(DATA_W)) u_alu (
    .a(a_q), .b(b_q), .shift(shift_q), .aluop(op_q), .c(alu_c), .status(alu_status)
  );
  always_comb begin
    state_d = state_q;
    rn_b_d = rn_b_q;
    rd_d = rd_q;
    readnum_d = readnum_q;
    shift_d = shift_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    status_d = status_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = RD_A;
        readnum_d = cmd_rn_a;
        rn_b_d = cmd_rn_b;
        rd_d = cmd_rd;
        shift_d = cmd_shift;
        op_d = cmd_aluop;
      end
      RD_A: begin
        state_d = RD_B;
        a_d = rf_data_out;
        readnum_d = rn_b_q;
      end
      RD_B: begin
        state_d = EXEC;
        b_d = rf_data_out;
      end
      EXEC: begin
        state_d = WB;
        c_d = alu_c;
        status_d = alu_status;
      end
      default: state_d = IDLE;
    endcase
    wr_d = state_q == EXEC;
    ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rn_b_q <= '0;
      rd_q <= '0;
      readnum_q <= '0;
      shift_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      status_q <= '0;
      wr_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      rn_b_q <= rn_b_d;
      rd_q <= rd_d;
      readnum_q <= readnum_d;
      shift_q <= shift_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      status_q <= status_d;
      wr_q <= wr_d;
      ready_q <= ready_d;
    end
  assign cmd_ready = ready_q;
  assign rf_readnum = readnum_q;
  assign rf_writenum = rd_q;
  assign rf_write = wr_q;
  assign rf_data_in = c_q;
  assign status = status_q;
  assign done = wr_q;
endmodule

// File: tb/tb_p3_exec_sequencer.sv
// tb_p3_exec_sequencer: sequencer plus behavioural 8x16 register file, checked against an arithmetic reference model.
module tb_p3_exec_sequencer;
`ifdef P3_STATUS_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_rn_a = '0, cmd_rn_b = '0, cmd_rd = '0;
  logic [1:0] cmd_shift = '0, cmd_aluop = '0;
  logic [2:0] rf_readnum, rf_writenum, status;
  logic [15:0] rf_data_out, rf_data_in;
  logic rf_write, done;
  logic tb_we = 1'b0;
  logic [2:0] tb_wn = '0;
  logic [15:0] tb_wd = '0;
  logic [15:0] rf [8];
  logic [15:0] mregs [8];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  p3_exec_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rn_a(cmd_rn_a), .cmd_rn_b(cmd_rn_b), .cmd_rd(cmd_rd), .cmd_shift(cmd_shift),
    .cmd_aluop(cmd_aluop), .rf_readnum(rf_readnum), .rf_data_out(rf_data_out),
    .rf_writenum(rf_writenum), .rf_write(rf_write), .rf_data_in(rf_data_in),
    .status(status), .done(done)
  );
  assign rf_data_out = rf[rf_readnum];
  always_ff @(posedge clk)
    if (rf_write) rf[rf_writenum] <= rf_data_in;
    else if (tb_we) rf[tb_wn] <= tb_wd;
  // returns {status, result} computed with plain integer arithmetic
  function automatic logic [18:0] ref_exec(input int a, input int b, input int sh, input int op);
    int bs, sa, sb, s, c;
    logic [15:0] cv;
    bit v;
    bs = sh == 1 ? (b * 2) % 65536 : sh == 2 ? b / 2 : sh == 3 ? b / 2 + (b >= 32768 ? 32768 : 0) : b;
    sa = a >= 32768 ? a - 65536 : a;
    sb = bs >= 32768 ? bs - 65536 : bs;
    s = op == 0 ? sa + sb : op == 1 ? sa - sb : 0;
    c = op == 0 ? (a + bs) % 65536 : op == 1 ? (a - bs + 65536) % 65536 : op == 2 ? (a & bs) : 65535 - bs;
    v = op < 2 && (s > 32767 || s < -32768);
    cv = c[15:0];
    return {FL & v, FL & (c >= 32768), c == 0, cv};
  endfunction
  task automatic load(input logic [2:0] idx, input logic [15:0] val);
    @(negedge clk);
    tb_we = 1'b1;
    tb_wn = idx;
    tb_wd = val;
    @(negedge clk);
    tb_we = 1'b0;
    mregs[idx] = val;
  endtask
  task automatic run_cmd(input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd,
                         input logic [1:0] sh, input logic [1:0] op);
    logic [18:0] e;
    int n;
    e = ref_exec(mregs[ra], mregs[rb], sh, op);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rn_a = ra;
    cmd_rn_b = rb;
    cmd_rd = rd;
    cmd_shift = sh;
    cmd_aluop = op;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    {cmd_rn_a, cmd_rn_b, cmd_rd} = 9'($urandom);
    for (int k = 1; k <= 4; k++) begin
      n_cmp++;
      if (cmd_ready !== 1'b0 || done !== (k == 4) || rf_write !== (k == 4)) begin
        n_bad++;
        $display("FAIL busy_T+%0d: ready=%b done=%b wr=%b, required 0 %b %b", k, cmd_ready, done, rf_write, k == 4, k == 4);
      end
      if (k <= 2) begin
        n_cmp++;
        if (rf_readnum !== (k == 1 ? ra : rb)) begin
          n_bad++;
          $display("FAIL readnum_T+%0d: got %0d, required %0d", k, rf_readnum, k == 1 ? ra : rb);
        end
      end
      if (k == 4) begin
        n_cmp++;
        if (rf_writenum !== rd || rf_data_in !== e[15:0]) begin
          n_bad++;
          $display("FAIL wb_port: writenum=%0d data=%h, required %0d %h", rf_writenum, rf_data_in, rd, e[15:0]);
        end
      end
      @(negedge clk);
    end
    mregs[rd] = e[15:0];
    n_cmp++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || status !== e[18:16] || rf[rd] !== e[15:0]) begin
      n_bad++;
      $display("FAIL result r%0d: ready=%b done=%b status=%b data=%h, required 1 0 %b %h",
               rd, cmd_ready, done, status, rf[rd], e[18:16], e[15:0]);
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || rf_write !== 1'b0 || done !== 1'b0 || status !== 3'b000 ||
        rf_readnum !== 3'd0 || rf_writenum !== 3'd0 || rf_data_in !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_state: ready=%b wr=%b done=%b st=%b rn=%0d wn=%0d din=%h, required 1 0 0 000 0 0 0000",
               cmd_ready, rf_write, done, status, rf_readnum, rf_writenum, rf_data_in);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) load(3'(i), 16'h0000);
  endtask
  task automatic test_add;
    load(0, 16'h0005);
    load(1, 16'h0003);
    run_cmd(0, 1, 2, 2'b00, 2'b00);
    n_cmp++;
    if (rf[2] !== 16'h0008 || status !== 3'b000) begin
      n_bad++;
      $display("FAIL add_basic: r2=%h st=%b, required 0008 000", rf[2], status);
    end
  endtask
  task automatic test_sub_zero;
    run_cmd(1, 1, 3, 2'b00, 2'b01);
    n_cmp++;
    if (rf[3] !== 16'h0000 || status !== 3'b001) begin
      n_bad++;
      $display("FAIL sub_zero: r3=%h st=%b, required 0000 001", rf[3], status);
    end
  endtask
  task automatic test_shift;
    load(4, 16'h0000);
    load(5, 16'h8001);
    run_cmd(4, 5, 6, 2'b11, 2'b00);
    n_cmp++;
    if (rf[6] !== 16'hC000 || status !== {1'b0, FL, 1'b0}) begin
      n_bad++;
      $display("FAIL shift_asr: r6=%h st=%b, required c000 %b", rf[6], status, {1'b0, FL, 1'b0});
    end
    run_cmd(4, 5, 6, 2'b10, 2'b00);
    n_cmp++;
    if (rf[6] !== 16'h4000 || status !== 3'b000) begin
      n_bad++;
      $display("FAIL shift_lsr: r6=%h st=%b, required 4000 000", rf[6], status);
    end
  endtask
  task automatic test_overflow;
    load(0, 16'h7FFF);
    load(1, 16'h0001);
    run_cmd(0, 1, 7, 2'b00, 2'b00);
    n_cmp++;
    if (rf[7] !== 16'h8000 || status !== (FL ? 3'b110 : 3'b000)) begin
      n_bad++;
      $display("FAIL overflow: r7=%h st=%b, required 8000 %b", rf[7], status, FL ? 3'b110 : 3'b000);
    end
  endtask
  task automatic start_cmd(input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rn_a = ra;
    cmd_rn_b = rb;
    cmd_rd = rd;
    cmd_shift = 2'b00;
    cmd_aluop = 2'b00;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic test_reset_mid;
    int wr_seen;
    load(1, 16'h0001);
    run_cmd(1, 1, 3, 2'b00, 2'b01);
    load(2, 16'hBEEF);
    for (int stage = 3; stage <= 4; stage++) begin
      start_cmd(0, 1, 2);
      repeat (stage - 1) @(negedge clk);
      if (stage == 4) begin
        n_cmp++;
        if (rf_write !== 1'b1) begin
          n_bad++;
          $display("FAIL pre_reset_wb: wr=%b, required 1", rf_write);
        end
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (cmd_ready !== 1'b1 || rf_write !== 1'b0 || status !== 3'b000 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_T+%0d: ready=%b wr=%b st=%b done=%b, required 1 0 000 0", stage, cmd_ready, rf_write, status, done);
      end
      wr_seen = 0;
      repeat (3) begin
        @(negedge clk);
        if (rf_write) wr_seen++;
      end
      rst_n = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (rf_write) wr_seen++;
      end
      n_cmp++;
      if (wr_seen != 0 || rf[2] !== 16'hBEEF || cmd_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_no_wb_T+%0d: writes=%0d r2=%h ready=%b, required 0 beef 1", stage, wr_seen, rf[2], cmd_ready);
      end
    end
  endtask
  task automatic test_back_to_back;
    load(0, 16'h0005);
    load(1, 16'h0003);
    @(negedge clk);
    cmd_valid = 1'b1;
    {cmd_rn_a, cmd_rn_b, cmd_rd, cmd_shift, cmd_aluop} = {3'd0, 3'd1, 3'd2, 2'b00, 2'b00};
    @(negedge clk);
    {cmd_rn_a, cmd_rn_b, cmd_rd} = {3'd2, 3'd2, 3'd3};
    for (int k = 1; k <= 4; k++) begin
      n_cmp++;
      if (cmd_ready !== 1'b0 || done !== (k == 4)) begin
        n_bad++;
        $display("FAIL b2b_busy_T+%0d: ready=%b done=%b, required 0 %b", k, cmd_ready, done, k == 4);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1 || rf[2] !== 16'h0008) begin
      n_bad++;
      $display("FAIL b2b_first: ready=%b r2=%h, required 1 0008", cmd_ready, rf[2]);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if (cmd_ready !== 1'b0 || rf_readnum !== 3'd2) begin
      n_bad++;
      $display("FAIL b2b_accept: ready=%b readnum=%0d, required 0 2", cmd_ready, rf_readnum);
    end
    repeat (4) @(negedge clk);
    mregs[2] = 16'h0008;
    mregs[3] = 16'h0010;
    n_cmp++;
    if (rf[3] !== 16'h0010 || cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_second: r3=%h ready=%b, required 0010 1", rf[3], cmd_ready);
    end
  endtask
  task automatic test_random;
    logic [15:0] corner [6];
    corner = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001, 16'h8001};
    for (int i = 0; i < 8; i++) load(3'(i), 16'($urandom));
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        load(3'($urandom), $urandom_range(0, 1) ? corner[$urandom_range(0, 5)] : 16'($urandom));
      run_cmd(3'($urandom), 3'($urandom), 3'($urandom), 2'($urandom), 2'($urandom));
    end
  endtask
  initial begin
    test_reset;
    test_add;
    test_sub_zero;
    test_shift;
    test_overflow;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
